// File: rtl/wb_commit_arb_pkg.sv
// Shared types, defaults and small helpers for the register-file writeback commit arbiter.
package wb_commit_arb_pkg;

  localparam int WB_XLEN    = 32;
  localparam int WB_NUM_SRC = 4;
  localparam int WB_NUM_WP  = 1;
  localparam int WB_QDEPTH  = 4;

  localparam int WB_SRC_PIPE = 0;
  localparam int WB_SRC_MDU  = 1;
  localparam int WB_SRC_LSU  = 2;
  localparam int WB_SRC_CSR  = 3;

  typedef enum logic [2:0] {
    NO_STALL     = 3'd0,
    IMISS_STALL  = 3'd1,
    DMISS_STALL  = 3'd2,
    ALU_STALL    = 3'd3,
    FENCEI_STALL = 3'd4
  } stall_e;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

  function automatic logic is_gating_stall(input stall_e cause);
    case (cause)
      IMISS_STALL, DMISS_STALL, ALU_STALL, FENCEI_STALL: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  // x0 is never tracked, so its bit is forced low.
  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    logic [31:0] vec;
    vec     = 32'd0;
    vec[rd] = 1'b1;
    vec[0]  = 1'b0;
    return vec;
  endfunction

endpackage

// File: rtl/wb_commit_arb_if.sv
// Result-source handshake and RF write-port bundle of the writeback commit arbiter.
interface wb_commit_arb_if
  import wb_commit_arb_pkg::*;
#(
  parameter int XLEN    = WB_XLEN,
  parameter int NUM_SRC = WB_NUM_SRC,
  parameter int NUM_WP  = WB_NUM_WP,
  parameter int QDEPTH  = WB_QDEPTH
);

  logic [NUM_SRC-1:0]           src_valid_i;
  logic [NUM_SRC-1:0][4:0]      src_rd_i;
  logic [NUM_SRC-1:0][XLEN-1:0] src_data_i;
  logic [NUM_SRC-1:0]           src_ready_o;

  logic [NUM_WP-1:0]            wp_en_o;
  logic [NUM_WP-1:0][4:0]       wp_addr_o;
  logic [NUM_WP-1:0][XLEN-1:0]  wp_data_o;
  logic [31:0]                  busy_o;
  logic [$clog2(QDEPTH):0]      q_count_o;

  modport master (
    output src_valid_i, src_rd_i, src_data_i,
    input  src_ready_o, wp_en_o, wp_addr_o, wp_data_o, busy_o, q_count_o
  );

  modport slave (
    input  src_valid_i, src_rd_i, src_data_i,
    output src_ready_o, wp_en_o, wp_addr_o, wp_data_o, busy_o, q_count_o
  );

endinterface

// File: rtl/wb_commit_arb_queue.sv
// In-order overflow queue: multi-enqueue in source order, multi-dequeue from the head,
// plus an rd match per source and a busy bitmap over the valid entries.
module wb_commit_arb_queue
  import wb_commit_arb_pkg::*;
#(
  parameter  int XLEN    = WB_XLEN,
  parameter  int NUM_SRC = WB_NUM_SRC,
  parameter  int NUM_WP  = WB_NUM_WP,
  parameter  int QDEPTH  = WB_QDEPTH,
  localparam int AW      = $clog2(QDEPTH),
  localparam int CW      = AW + 1,
  localparam int PW      = $clog2(NUM_WP + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_SRC-1:0]           enq_i,
  input  logic [NUM_SRC-1:0][4:0]      src_rd_i,
  input  logic [NUM_SRC-1:0][XLEN-1:0] src_data_i,
  input  logic [PW-1:0]                deq_cnt_i,
  output logic [NUM_WP-1:0]            head_valid_o,
  output logic [NUM_WP-1:0][4:0]       head_rd_o,
  output logic [NUM_WP-1:0][XLEN-1:0]  head_data_o,
  output logic [NUM_SRC-1:0]           match_o,
  output logic [31:0]                  busy_o,
  output logic [CW-1:0]                count_o
);

  logic [QDEPTH-1:0][4:0]      rd_q, rd_d;
  logic [QDEPTH-1:0][XLEN-1:0] data_q, data_d;
  logic [AW-1:0]               head_q, head_d;
  logic [CW-1:0]               count_q, count_d;
  logic [QDEPTH-1:0]           ent_valid_s;
  logic [AW-1:0]               tail_s;
  logic [CW-1:0]               enq_n_s;

  // Occupancy view: which slots are live, the head window, CAM match and busy bitmap.
  always_comb begin
    ent_valid_s  = '0;
    head_valid_o = '0;
    head_rd_o    = '0;
    head_data_o  = '0;
    match_o      = '0;
    busy_o       = 32'd0;
    for (int i = 0; i < QDEPTH; i++) begin
      ent_valid_s[i] = ({1'b0, AW'(i) - head_q} < count_q);
      busy_o         = busy_o | (ent_valid_s[i] ? rd_onehot(rd_q[i]) : 32'd0);
    end
    for (int p = 0; p < NUM_WP; p++) begin
      head_valid_o[p] = (p < int'(count_q));
      head_rd_o[p]    = rd_q[head_q + AW'(p)];
      head_data_o[p]  = data_q[head_q + AW'(p)];
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < QDEPTH; i++) begin
        match_o[s] = match_o[s] | (ent_valid_s[i] && (rd_q[i] == src_rd_i[s]));
      end
    end
  end

  // Enqueued sources are packed contiguously behind the current tail in source order.
  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    tail_s  = head_q + count_q[AW-1:0];
    enq_n_s = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      rd_d[tail_s + enq_n_s[AW-1:0]]   = enq_i[s] ? src_rd_i[s]   : rd_d[tail_s + enq_n_s[AW-1:0]];
      data_d[tail_s + enq_n_s[AW-1:0]] = enq_i[s] ? src_data_i[s] : data_d[tail_s + enq_n_s[AW-1:0]];
      enq_n_s = enq_n_s + CW'(enq_i[s]);
    end
    head_d  = head_q + AW'(deq_cnt_i);
    count_d = count_q - CW'(deq_cnt_i) + enq_n_s;
  end

  // Queue state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      data_q  <= '0;
      head_q  <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      data_q  <= data_d;
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/wb_commit_arb.sv
// Writeback commit arbiter: drains the overflow queue first, grants remaining RF ports to
// sources in age order, and parks everything else in the queue while keeping WAW order.
module wb_commit_arb
  import wb_commit_arb_pkg::*;
#(
  parameter  int XLEN    = WB_XLEN,
  parameter  int NUM_SRC = WB_NUM_SRC,
  parameter  int NUM_WP  = WB_NUM_WP,
  parameter  int QDEPTH  = WB_QDEPTH,
  localparam int CW      = $clog2(QDEPTH) + 1,
  localparam int PW      = $clog2(NUM_WP + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  stall_e           stall_i,
  input  logic             flush_i,
  wb_commit_arb_if.slave   bus
);

  logic [NUM_WP-1:0]            wp_en_q, wp_en_d;
  logic [NUM_WP-1:0][4:0]       wp_addr_q, wp_addr_d;
  logic [NUM_WP-1:0][XLEN-1:0]  wp_data_q, wp_data_d;

  logic [NUM_WP-1:0]            head_valid_s;
  logic [NUM_WP-1:0][4:0]       head_rd_s;
  logic [NUM_WP-1:0][XLEN-1:0]  head_data_s;
  logic [NUM_SRC-1:0]           match_s;
  logic [31:0]                  q_busy_s;
  logic [31:0]                  wp_busy_s;
  logic [CW-1:0]                count_s;

  logic                         active_s;
  logic [PW-1:0]                deq_n_s;
  logic                         deq_stop_s;
  logic                         dup_s;
  logic                         take_s;
  logic [CW-1:0]                free_s;
  logic                         conflict_s;
  logic                         want_port_s;
  logic                         granted_s;
  logic                         gnt_s;
  logic                         enq_ok_s;
  logic                         zero_rd_s;
  logic [NUM_SRC-1:0]           enq_s;
  logic [NUM_SRC-1:0]           ready_s;

  wb_commit_arb_queue #(
    .XLEN    (XLEN),
    .NUM_SRC (NUM_SRC),
    .NUM_WP  (NUM_WP),
    .QDEPTH  (QDEPTH)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enq_i        (enq_s),
    .src_rd_i     (bus.src_rd_i),
    .src_data_i   (bus.src_data_i),
    .deq_cnt_i    (deq_n_s),
    .head_valid_o (head_valid_s),
    .head_rd_o    (head_rd_s),
    .head_data_o  (head_data_s),
    .match_o      (match_s),
    .busy_o       (q_busy_s),
    .count_o      (count_s)
  );

  // Port allocation: queue heads first, then sources by age; leftovers go to the queue.
  always_comb begin
    active_s    = rst_ni && !flush_i && !is_gating_stall(stall_i);
    wp_en_d     = '0;
    wp_addr_d   = '0;
    wp_data_d   = '0;
    deq_n_s     = '0;
    deq_stop_s  = 1'b0;
    dup_s       = 1'b0;
    take_s      = 1'b0;
    conflict_s  = 1'b0;
    want_port_s = 1'b0;
    granted_s   = 1'b0;
    gnt_s       = 1'b0;
    enq_ok_s    = 1'b0;
    zero_rd_s   = 1'b0;
    enq_s       = '0;
    ready_s     = '0;

    // Heads drain in order; stop at the first head whose rd already owns a port this cycle.
    for (int p = 0; p < NUM_WP; p++) begin
      dup_s = 1'b0;
      for (int j = 0; j < p; j++) begin
        dup_s = dup_s | (head_rd_s[j] == head_rd_s[p]);
      end
      take_s       = active_s && !deq_stop_s && head_valid_s[p] && !dup_s;
      deq_stop_s   = deq_stop_s | !take_s;
      wp_en_d[p]   = take_s;
      wp_addr_d[p] = take_s ? head_rd_s[p] : 5'd0;
      wp_data_d[p] = take_s ? head_data_s[p] : {XLEN{1'b0}};
      deq_n_s      = deq_n_s + PW'(take_s);
    end

    free_s = CW'(QDEPTH) - count_s + CW'(deq_n_s);

    for (int s = 0; s < NUM_SRC; s++) begin
      conflict_s = 1'b0;
      for (int j = 0; j < s; j++) begin
        conflict_s = conflict_s | (bus.src_valid_i[j] && (bus.src_rd_i[j] == bus.src_rd_i[s]));
      end
      zero_rd_s   = active_s && bus.src_valid_i[s] && (bus.src_rd_i[s] == 5'd0);
      want_port_s = active_s && bus.src_valid_i[s] && (bus.src_rd_i[s] != 5'd0) && !conflict_s;
      granted_s   = 1'b0;
      for (int p = 0; p < NUM_WP; p++) begin
        gnt_s        = want_port_s && !match_s[s] && !granted_s && !wp_en_d[p];
        wp_en_d[p]   = wp_en_d[p] | gnt_s;
        wp_addr_d[p] = gnt_s ? bus.src_rd_i[s] : wp_addr_d[p];
        wp_data_d[p] = gnt_s ? bus.src_data_i[s] : wp_data_d[p];
        granted_s    = granted_s | gnt_s;
      end
      enq_ok_s   = want_port_s && !granted_s && (free_s != '0);
      enq_s[s]   = enq_ok_s;
      free_s     = free_s - CW'(enq_ok_s);
      ready_s[s] = zero_rd_s | granted_s | enq_ok_s;
    end
  end

  // Registered RF write ports.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp_en_q   <= '0;
      wp_addr_q <= '0;
      wp_data_q <= '0;
    end else begin
      wp_en_q   <= wp_en_d;
      wp_addr_q <= wp_addr_d;
      wp_data_q <= wp_data_d;
    end
  end

  // Registers currently being written also count as busy.
  always_comb begin
    wp_busy_s = 32'd0;
    for (int p = 0; p < NUM_WP; p++) begin
      wp_busy_s = wp_busy_s | (wp_en_q[p] ? rd_onehot(wp_addr_q[p]) : 32'd0);
    end
  end

  assign bus.src_ready_o = ready_s;
  assign bus.wp_en_o     = wp_en_q;
  assign bus.wp_addr_o   = wp_addr_q;
  assign bus.wp_data_o   = wp_data_q;
  assign bus.busy_o      = q_busy_s | wp_busy_s;
  assign bus.q_count_o   = count_s;

endmodule

// File: tb/tb_wb_commit_arb.sv
// Directed and randomized bench for wb_commit_arb; expectations come from a
// queue-based reference model of the arbitration rules.
module tb_wb_commit_arb;
  import wb_commit_arb_pkg::*;

  localparam int NS = 4;
  localparam int NW = 1;
  localparam int QD = 4;
  localparam int XL = 32;

  logic   clk = 1'b0;
  logic   rst_n;
  stall_e stall;
  logic   flush;

  wb_commit_arb_if #(.XLEN(XL), .NUM_SRC(NS), .NUM_WP(NW), .QDEPTH(QD)) bus ();

  wb_commit_arb #(.XLEN(XL), .NUM_SRC(NS), .NUM_WP(NW), .QDEPTH(QD)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .stall_i (stall),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  wb_entry_t      mq[$];
  wb_entry_t      nq[$];
  wb_entry_t      cur_wr[$];
  wb_entry_t      nxt_wr[$];
  logic [NS-1:0]  exp_ready;
  logic [NS-1:0]  obs_ready;
  logic [XL-1:0]  rf [32];
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit has_rd(input wb_entry_t l[$], input logic [4:0] rd);
    foreach (l[i]) if (l[i].rd == rd) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: queue drains first, then sources by age; WAW and same-cycle rules from the rules list.
  task automatic model_eval();
    bit        gated;
    bit        older;
    wb_entry_t e;
    gated = !rst_n || flush ||
            (stall inside {IMISS_STALL, DMISS_STALL, ALU_STALL, FENCEI_STALL});
    exp_ready = '0;
    nxt_wr.delete();
    nq = mq;
    if (!gated) begin
      while (nxt_wr.size() < NW && nq.size() > 0 && !has_rd(nxt_wr, nq[0].rd)) begin
        e = nq.pop_front();
        nxt_wr.push_back(e);
      end
      for (int s = 0; s < NS; s++) begin
        if (!bus.src_valid_i[s]) continue;
        e.rd   = bus.src_rd_i[s];
        e.data = bus.src_data_i[s];
        if (e.rd == 5'd0) begin
          exp_ready[s] = 1'b1;
          continue;
        end
        older = 1'b0;
        for (int j = 0; j < s; j++)
          if (bus.src_valid_i[j] && bus.src_rd_i[j] == e.rd) older = 1'b1;
        if (older) continue;
        if (!has_rd(mq, e.rd) && nxt_wr.size() < NW) begin
          nxt_wr.push_back(e);
          exp_ready[s] = 1'b1;
        end else if (nq.size() < QD) begin
          nq.push_back(e);
          exp_ready[s] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    logic [31:0] b;
    #2;
    model_eval();
    obs_ready = bus.src_ready_o;
    check_eq("src_ready", 64'(obs_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mq.delete();
      cur_wr.delete();
    end else begin
      mq     = nq;
      cur_wr = nxt_wr;
    end
    for (int p = 0; p < NW; p++) begin
      check_eq("wp_en", 64'(bus.wp_en_o[p]), 64'(p < cur_wr.size()));
      if (p < cur_wr.size()) begin
        check_eq("wp_addr", 64'(bus.wp_addr_o[p]), 64'(cur_wr[p].rd));
        check_eq("wp_data", 64'(bus.wp_data_o[p]), 64'(cur_wr[p].data));
        rf[bus.wp_addr_o[p]] = bus.wp_data_o[p];
      end else if (!rst_n) begin
        check_eq("rst_addr", 64'(bus.wp_addr_o[p]), 64'd0);
        check_eq("rst_data", 64'(bus.wp_data_o[p]), 64'd0);
      end
    end
    b = 32'd0;
    foreach (mq[i]) b[mq[i].rd] = 1'b1;
    foreach (cur_wr[i]) b[cur_wr[i].rd] = 1'b1;
    b[0] = 1'b0;
    check_eq("busy", 64'(bus.busy_o), 64'(b));
    check_eq("q_count", 64'(bus.q_count_o), 64'(mq.size()));
    for (int s = 0; s < NS; s++)
      if (bus.src_valid_i[s] && exp_ready[s]) bus.src_valid_i[s] = 1'b0;
  endtask

  task automatic drive_src(input int s, input logic [4:0] rd, input logic [31:0] d);
    bus.src_valid_i[s] = 1'b1;
    bus.src_rd_i[s]    = rd;
    bus.src_data_i[s]  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [4:0] drain [5];
    rst_n           = 1'b0;
    stall           = NO_STALL;
    flush           = 1'b0;
    bus.src_valid_i = 4'hF;
    bus.src_rd_i    = '0;
    bus.src_data_i  = '0;
    foreach (rf[i]) rf[i] = 32'd0;

    // T1 reset with all sources asserting valid
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t1_ready", 64'(obs_ready), 64'd0);
      check_eq("t1_wp_en", 64'(bus.wp_en_o), 64'd0);
      check_eq("t1_busy", 64'(bus.busy_o), 64'd0);
      check_eq("t1_qcnt", 64'(bus.q_count_o), 64'd0);
    end
    rst_n           = 1'b1;
    bus.src_valid_i = 4'h0;
    idle(1);

    // T2 port contention
    drive_src(0, 5'd5, 32'h11);
    drive_src(2, 5'd7, 32'h22);
    step();
    check_eq("t2_ready", 64'(obs_ready), 64'b0101);
    check_eq("t2_addr1", 64'(bus.wp_addr_o[0]), 64'd5);
    check_eq("t2_busy7", 64'(bus.busy_o[7]), 64'd1);
    step();
    check_eq("t2_addr2", 64'(bus.wp_addr_o[0]), 64'd7);
    check_eq("t2_data2", 64'(bus.wp_data_o[0]), 64'h22);
    idle(2);

    // T3 WAW behind a queued entry
    drive_src(0, 5'd1, 32'h1);
    drive_src(1, 5'd9, 32'hAA);
    step();
    check_eq("t3_qcnt", 64'(bus.q_count_o), 64'd1);
    drive_src(0, 5'd9, 32'hBB);
    step();
    check_eq("t3_ready", 64'(obs_ready), 64'b0001);
    check_eq("t3_first", 64'(bus.wp_data_o[0]), 64'hAA);
    step();
    check_eq("t3_second", 64'(bus.wp_data_o[0]), 64'hBB);
    check_eq("t3_rf9", 64'(rf[9]), 64'hBB);
    idle(2);

    // T4 same rd in one cycle
    drive_src(1, 5'd3, 32'd1);
    drive_src(3, 5'd3, 32'd2);
    step();
    check_eq("t4_ready1", 64'(obs_ready), 64'b0010);
    check_eq("t4_data1", 64'(bus.wp_data_o[0]), 64'd1);
    step();
    check_eq("t4_ready2", 64'(obs_ready), 64'b1000);
    check_eq("t4_data2", 64'(bus.wp_data_o[0]), 64'd2);
    check_eq("t4_rf3", 64'(rf[3]), 64'd2);
    idle(2);

    // T5 fill queue, gate with DMISS, then drain in order
    for (int s = 0; s < NS; s++) drive_src(s, 5'(10 + s), 32'(32'h100 + 10 + s));
    step();
    drive_src(0, 5'd14, 32'h10E);
    drive_src(1, 5'd15, 32'h10F);
    step();
    check_eq("t5_full", 64'(bus.q_count_o), 64'd4);
    stall = DMISS_STALL;
    drive_src(2, 5'd16, 32'h110);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t5_gate_ready", 64'(obs_ready), 64'd0);
      check_eq("t5_gate_en", 64'(bus.wp_en_o), 64'd0);
      check_eq("t5_gate_qcnt", 64'(bus.q_count_o), 64'd4);
    end
    stall = NO_STALL;
    drain = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t5_drain", 64'(bus.wp_addr_o[0]), 64'(drain[i]));
    end
    idle(2);

    // T6 x0 and flush
    drive_src(0, 5'd0, 32'h55);
    step();
    check_eq("t6_x0_ready", 64'(obs_ready), 64'b0001);
    check_eq("t6_x0_en", 64'(bus.wp_en_o), 64'd0);
    drive_src(0, 5'd20, 32'h20);
    drive_src(1, 5'd21, 32'h21);
    drive_src(2, 5'd22, 32'h22);
    step();
    flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("t6_flush_en", 64'(bus.wp_en_o), 64'd0);
      check_eq("t6_flush_qcnt", 64'(bus.q_count_o), 64'd2);
    end
    flush = 1'b0;
    step();
    check_eq("t6_data21", 64'(bus.wp_data_o[0]), 64'h21);
    step();
    check_eq("t6_data22", 64'(bus.wp_data_o[0]), 64'h22);
    idle(2);

    // Random traffic with small rd range to provoke WAW and same-cycle conflicts
    for (int c = 0; c < 1500; c++) begin
      for (int s = 0; s < NS; s++)
        if (!bus.src_valid_i[s] && $urandom_range(0, 99) < 40)
          drive_src(s, 5'($urandom_range(0, 7)), $urandom);
      stall = ($urandom_range(0, 99) < 85) ? NO_STALL : stall_e'($urandom_range(1, 4));
      flush = ($urandom_range(0, 99) < 5);
      step();
    end
    stall           = NO_STALL;
    flush           = 1'b0;
    bus.src_valid_i = 4'h0;
    idle(8);
    check_eq("final_qcnt", 64'(bus.q_count_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
